// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end sharing one 32x32 multiplier (low 32 bits kept).
// Optional MULT_ARB_ZERO_BYPASS_EN: a zero operand finishes one cycle after accept.
module mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  assign p = a * b;
endmodule

module mult_arbiter #(
  parameter int MULT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  req_ready,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_result,
  input  logic [1:0]  resp_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MULT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        gnt, last_gnt, sel;
  logic [31:0] op_a, op_b, prod, in_a, in_b;
  logic [3:0]  cnt_load;

  mult u_mult (.a(op_a), .b(op_b), .p(prod));

  // Contention goes to whoever was not served last; otherwise the lone requester.
  assign sel  = (req_valid == 2'b11) ? ~last_gnt : req_valid[1];
  assign in_a = sel ? req_a1 : req_a0;
  assign in_b = sel ? req_b1 : req_b0;

`ifdef MULT_ARB_ZERO_BYPASS_EN
  // A zero operand needs no settle time; the product register still yields 0.
  assign cnt_load = ((in_a == 32'd0) || (in_b == 32'd0)) ? 4'd0 : CNT_INIT;
`else
  assign cnt_load = CNT_INIT;
`endif

  always_comb begin
    req_ready = 2'b00;
    if (rst_n && state == IDLE && req_valid[sel]) req_ready = {sel, ~sel};
  end

  assign resp_valid = (state == DONE) ? {gnt, ~gnt} : 2'b00;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;
      op_a        <= 32'd0;
      op_b        <= 32'd0;
      resp_result <= 32'd0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          op_a     <= in_a;
          op_b     <= in_b;
          gnt      <= sel;
          last_gnt <= sel;
          cnt      <= cnt_load;
          state    <= CALC;
        end
        CALC: if (cnt == 4'd0) begin
          resp_result <= prod;
          state       <= DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        DONE: if (resp_ready[gnt]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter at MULT_CYCLES=2.
module tb_mult_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1, resp_result;
  logic        busy;
  int checks = 0, failures = 0;

  mult_arbiter #(.MULT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Count edges until a response shows, giving up after 20.
  task automatic wait_resp(output int n);
    n = 0;
    while (resp_valid == 2'b00 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    req_valid = 2'b11; resp_ready = 2'b00;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    rst_n = 1'b0;
    #3;
    checks++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_result !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: ready=%b rvalid=%b result=%h busy=%b want 00 00 0 0",
               req_ready, resp_valid, resp_result, busy);
    end
    tick();
    req_valid = 2'b00;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic;
    int n;
    req_a0 = 7; req_b0 = 6; resp_ready = 2'b11; req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL basic_ready: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if (busy !== 1'b1 || resp_valid !== 2'b00) begin
      failures++; $display("FAIL basic_calc: busy=%b rvalid=%b want 1 00", busy, resp_valid);
    end
    wait_resp(n);
    checks++;
    if (n != 2 || resp_valid !== 2'b01 || resp_result !== 32'd42) begin
      failures++;
      $display("FAIL basic_resp: lat=%0d rvalid=%b result=%0d want 2 01 42", n, resp_valid, resp_result);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00) begin
      failures++; $display("FAIL basic_idle: busy=%b rvalid=%b want 0 00", busy, resp_valid);
    end
  endtask

  task automatic test_round_robin;
    int n;
    logic [1:0]  exp_oh;
    logic [31:0] exp_res;
    do_reset();
    req_a0 = 3; req_b0 = 5; req_a1 = 4; req_b1 = 4; resp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_oh  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_res = (i % 2 == 0) ? 32'd15 : 32'd16;
      checks++;
      if (req_ready !== exp_oh) begin
        failures++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, exp_oh);
      end
      tick();
      wait_resp(n);
      checks++;
      if (resp_valid !== exp_oh || resp_result !== exp_res) begin
        failures++;
        $display("FAIL rr_resp%0d: rvalid=%b result=%0d want %b %0d", i, resp_valid, resp_result, exp_oh, exp_res);
      end
      tick();
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_overflow;
    int n;
    req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd2; resp_ready = 2'b11; req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++; $display("FAIL ovf_ready: got %b want 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    wait_resp(n);
    checks++;
    if (resp_valid !== 2'b10 || resp_result !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL ovf_ffff: rvalid=%b result=%h want 10 fffffffe", resp_valid, resp_result);
    end
    tick();
    req_a0 = 32'h0001_0000; req_b0 = 32'h0001_0000; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_resp(n);
    checks++;
    if (resp_valid !== 2'b01 || resp_result !== 32'd0) begin
      failures++; $display("FAIL ovf_2to32: rvalid=%b result=%h want 01 0", resp_valid, resp_result);
    end
    tick();
  endtask

  task automatic test_hold;
    int n;
    req_a0 = 9; req_b0 = 9; resp_ready = 2'b00; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_resp(n);
    for (int k = 0; k < 5; k++) begin
      resp_ready = (k % 2 == 1) ? 2'b10 : 2'b00;
      tick();
      checks++;
      if (resp_valid !== 2'b01 || resp_result !== 32'd81 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold%0d: rvalid=%b result=%0d busy=%b want 01 81 1", k, resp_valid, resp_result, busy);
      end
    end
    resp_ready = 2'b01;
    tick();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00) begin
      failures++; $display("FAIL hold_release: busy=%b rvalid=%b want 0 00", busy, resp_valid);
    end
  endtask

  task automatic test_reset_mid;
    int n, seen;
    req_a0 = 2; req_b0 = 3; resp_ready = 2'b11; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || resp_result !== 32'd0 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL midreset: busy=%b rvalid=%b result=%0d ready=%b want 0 00 0 00", busy, resp_valid, resp_result, req_ready);
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (resp_valid != 2'b00) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL midreset_noresp: saw %0d responses want 0", seen);
    end
    req_a0 = 5; req_b0 = 5; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_resp(n);
    checks++;
    if (n != 2 || resp_valid !== 2'b01 || resp_result !== 32'd25) begin
      failures++;
      $display("FAIL midreset_next: lat=%0d rvalid=%b result=%0d want 2 01 25", n, resp_valid, resp_result);
    end
    tick();
  endtask

  task automatic test_zero;
    int n, exp_n;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    req_a0 = 0; req_b0 = 9; resp_ready = 2'b11; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_resp(n);
    checks++;
    if (n != exp_n || resp_valid !== 2'b01 || resp_result !== 32'd0) begin
      failures++;
      $display("FAIL zero: lat=%0d rvalid=%b result=%0d want %0d 01 0", n, resp_valid, resp_result, exp_n);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_overflow();
    test_hold();
    test_reset_mid();
    test_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
